// File: rtl/crossing_pkg.sv
// Shared types and constants for the crossing sequencer: phase encoding,
// seven-segment glyphs, lamp-per-phase mapping and elaboration-time BCD helpers.
package crossing_pkg;

  typedef enum logic [1:0] {
    GREEN_A  = 2'd0,
    CLEAR_AB = 2'd1,
    GREEN_B  = 2'd2,
    CLEAR_BA = 2'd3
  } phase_e;

  // Segment order {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef struct packed {
    logic red_a;
    logic green_a;
    logic red_b;
    logic green_b;
  } lamps_t;

  function automatic lamps_t lamps_for(phase_e p);
    lamps_t l;
    l = '{red_a: 1'b1, green_a: 1'b0, red_b: 1'b1, green_b: 1'b0};
    unique case (p)
      GREEN_A: begin l.red_a = 1'b0; l.green_a = 1'b1; end
      GREEN_B: begin l.red_b = 1'b0; l.green_b = 1'b1; end
      default: ;
    endcase
    return l;
  endfunction

  function automatic phase_e next_phase(phase_e p);
    return phase_e'(2'(p) + 2'd1);
  endfunction

  function automatic logic is_green(phase_e p);
    return (p == GREEN_A) || (p == GREEN_B);
  endfunction

  // Two-digit decimal to packed BCD; only ever evaluated on parameters.
  function automatic logic [7:0] to_bcd(int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-decimal codes blank the digit.
module bcd_to_7seg
  import crossing_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default ahead of the case keeps this purely combinational (no latch).
    seg = 7'h00;
    unique case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/crossing_sequencer.sv
// Two-approach crossing controller: phase FSM, tick prescaler, BCD countdown
// and pedestrian request latch driving lamps and a two-digit display.
module crossing_sequencer
  import crossing_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned GREEN_A_SEC = 20,
  parameter int unsigned GREEN_B_SEC = 15,
  parameter int unsigned CLEAR_SEC   = 3,
  parameter int unsigned PED_CUT     = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ped_req,
  input  logic       hold,
  output logic       LED_RED_A,
  output logic       LED_GREEN_A,
  output logic       LED_RED_B,
  output logic       LED_GREEN_B,
  output logic [6:0] SS1,
  output logic [6:0] SS2,
  output logic [1:0] phase,
  output logic       ped_ack
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [7:0] DUR_GREEN_A = to_bcd(GREEN_A_SEC);
  localparam logic [7:0] DUR_GREEN_B = to_bcd(GREEN_B_SEC);
  localparam logic [7:0] DUR_CLEAR   = to_bcd(CLEAR_SEC);
  localparam logic [7:0] CUT_BCD     = to_bcd(PED_CUT);

  function automatic logic [7:0] dur_of(phase_e p);
    unique case (p)
      GREEN_A: return DUR_GREEN_A;
      GREEN_B: return DUR_GREEN_B;
      default: return DUR_CLEAR;
    endcase
  endfunction

  phase_e          state_q;
  logic [7:0]      count_q;
  logic [PW-1:0]   presc_q;
  logic            ped_pending_q;
  logic            ped_ack_q;

  logic            tick;
  logic            pend_d;
  logic            truncate;
  logic [7:0]      count_dec_d;
  phase_e          state_next;
  lamps_t          lamps;

  assign tick       = (presc_q == PRESC_LAST) && !hold;
  assign pend_d     = ped_pending_q | ped_req;
  // Packed BCD orders the same as the decimal value, so a plain compare works.
  assign truncate   = is_green(state_q) && pend_d && (count_q > CUT_BCD);
  assign state_next = next_phase(state_q);

  // Borrow from the tens digit when the units digit is zero (20 -> 19).
  assign count_dec_d = (count_q[3:0] == 4'd0) ? {count_q[7:4] - 4'd1, 4'd9}
                                             : {count_q[7:4], count_q[3:0] - 4'd1};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and active-low.
    if (!rstn) begin
      state_q       <= GREEN_A;
      count_q       <= DUR_GREEN_A;
      presc_q       <= '0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      ped_ack_q     <= 1'b0;
      ped_pending_q <= pend_d;
      if (!hold) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
      end
      if (truncate) begin
        count_q <= CUT_BCD;
      end else if (tick) begin
        if (count_q == 8'h01) begin
          state_q <= state_next;
          count_q <= dur_of(state_next);
          if (!is_green(state_next) && pend_d) begin
            ped_ack_q     <= 1'b1;
            ped_pending_q <= 1'b0;
          end
        end else begin
          count_q <= count_dec_d;
        end
      end
    end
  end

  assign lamps       = lamps_for(state_q);
  assign LED_RED_A   = lamps.red_a;
  assign LED_GREEN_A = lamps.green_a;
  assign LED_RED_B   = lamps.red_b;
  assign LED_GREEN_B = lamps.green_b;
  assign phase       = 2'(state_q);
  assign ped_ack     = ped_ack_q;

  bcd_to_7seg u_tens (
    .bcd (count_q[7:4]),
    .seg (SS1)
  );

  bcd_to_7seg u_units (
    .bcd (count_q[3:0]),
    .seg (SS2)
  );

endmodule

// File: tb/tb_crossing_sequencer.sv
// Self-checking bench: a decimal behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_crossing_sequencer;

  localparam int TICK_DIV = 4;
  localparam int G_A      = 20;
  localparam int G_B      = 15;
  localparam int CLR      = 3;
  localparam int CUT      = 5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ped_req = 1'b0;
  logic       hold = 1'b0;
  logic       LED_RED_A, LED_GREEN_A, LED_RED_B, LED_GREEN_B;
  logic [6:0] SS1, SS2;
  logic [1:0] phase;
  logic       ped_ack;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  crossing_sequencer #(
    .TICK_DIV(TICK_DIV), .GREEN_A_SEC(G_A), .GREEN_B_SEC(G_B),
    .CLEAR_SEC(CLR), .PED_CUT(CUT)
  ) dut (
    .clk(clk), .rstn(rstn), .ped_req(ped_req), .hold(hold),
    .LED_RED_A(LED_RED_A), .LED_GREEN_A(LED_GREEN_A),
    .LED_RED_B(LED_RED_B), .LED_GREEN_B(LED_GREEN_B),
    .SS1(SS1), .SS2(SS2), .phase(phase), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (decimal count, integer phase) ----------
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int m_phase, m_cnt, m_presc;
  bit m_pend, m_ack, m_req, m_tick;

  function automatic int dur(int ph);
    if (ph == 0) return G_A;
    if (ph == 2) return G_B;
    return CLR;
  endfunction

  // {red_a, green_a, red_b, green_b}
  function automatic logic [3:0] exp_lamps(int ph);
    if (ph == 0) return 4'b0110;
    if (ph == 2) return 4'b1001;
    return 4'b1010;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase = 0; m_cnt = G_A; m_presc = 0; m_pend = 0; m_ack = 0;
    end else begin
      m_req  = m_pend || ped_req;
      m_tick = (m_presc == TICK_DIV - 1) && !hold;
      m_ack  = 0;
      if (!hold) m_presc = (m_presc + 1) % TICK_DIV;
      if ((m_phase % 2 == 0) && m_req && m_cnt > CUT) begin
        m_cnt  = CUT;
        m_pend = m_req;
      end else if (m_tick && m_cnt == 1) begin
        m_phase = (m_phase + 1) % 4;
        m_cnt   = dur(m_phase);
        if (m_phase % 2 == 1 && m_req) begin
          m_ack = 1; m_pend = 0;
        end else begin
          m_pend = m_req;
        end
      end else begin
        if (m_tick) m_cnt = m_cnt - 1;
        m_pend = m_req;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", 32'(phase), 32'(m_phase));
      check("lamps", 32'({LED_RED_A, LED_GREEN_A, LED_RED_B, LED_GREEN_B}), 32'(exp_lamps(m_phase)));
      check("ss1", 32'(SS1), 32'(seg_tbl[m_cnt / 10]));
      check("ss2", 32'(SS2), 32'(seg_tbl[m_cnt % 10]));
      check("ped_ack", 32'(ped_ack), 32'(m_ack));
    end
  end

  // ---------------- directed stimulus ----------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One reset edge; on return zero edges have elapsed since release.
  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_disp(input string name, input logic [6:0] s1, input logic [6:0] s2);
    check({name, "_ss1"}, 32'(SS1), 32'(s1));
    check({name, "_ss2"}, 32'(SS2), 32'(s2));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_lamps", 32'({LED_RED_A, LED_GREEN_A, LED_RED_B, LED_GREEN_B}), 32'(4'b0110));
    check_disp("rst", 7'h5B, 7'h3F);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ack", 32'(ped_ack), 32'd0);

    // Free run: first decrement on the 4th edge, borrows, phase lengths
    step(3);  check_disp("e3_still20", 7'h5B, 7'h3F);
    step(1);  check_disp("e4_19", 7'h06, 7'h6F);
    step(39); check_disp("e43_10", 7'h06, 7'h3F);
    step(1);  check_disp("e44_09", 7'h3F, 7'h6F);
    step(35); check_disp("e79_01", 7'h3F, 7'h06);
    check("e79_phase", 32'(phase), 32'd0);
    step(1);  check("e80_phase", 32'(phase), 32'd1);
    check_disp("e80_clear03", 7'h3F, 7'h4F);
    check("e80_lamps", 32'({LED_RED_A, LED_GREEN_A, LED_RED_B, LED_GREEN_B}), 32'(4'b1010));
    step(12); check("e92_phase", 32'(phase), 32'd2);
    step(60); check("e152_phase", 32'(phase), 32'd3);
    step(11); check("e163_phase", 32'(phase), 32'd3);
    step(1);  check("e164_phase", 32'(phase), 32'd0);

    // Pedestrian truncation at count 12, then a late request at count 03
    do_reset();
    step(32); check_disp("ped_e32_12", 7'h06, 7'h5B);
    ped_req = 1'b1;
    step(1);  ped_req = 1'b0;
    check_disp("ped_cut05", 7'h3F, 7'h6D);
    step(18); check("ped_e51_phase", 32'(phase), 32'd0);
    step(1);  check("ped_e52_phase", 32'(phase), 32'd1);
    check("ped_e52_ack", 32'(ped_ack), 32'd1);
    step(1);  check("ped_e53_ack", 32'(ped_ack), 32'd0);
    step(59); check_disp("ped_e112_03", 7'h3F, 7'h4F);
    ped_req = 1'b1;
    step(1);  ped_req = 1'b0;
    check_disp("ped_late_no_cut", 7'h3F, 7'h4F);
    step(10); check("ped_e123_ack", 32'(ped_ack), 32'd0);
    step(1);  check("ped_e124_phase", 32'(phase), 32'd3);
    check("ped_e124_ack", 32'(ped_ack), 32'd1);

    // Hold for 10 cycles mid-GREEN_B at count 13
    do_reset();
    step(100); check_disp("hold_e100_13", 7'h06, 7'h4F);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_disp("hold_frozen", 7'h06, 7'h4F);
      check("hold_phase", 32'(phase), 32'd2);
      check("hold_lamps", 32'({LED_RED_A, LED_GREEN_A, LED_RED_B, LED_GREEN_B}), 32'(4'b1001));
    end
    hold = 1'b0;
    step(51); check("hold_e161_phase", 32'(phase), 32'd2);
    step(1);  check("hold_e162_phase", 32'(phase), 32'd3);

    // Reset mid-GREEN_B at count 07 with a request on the reset edge
    do_reset();
    step(124); check_disp("rst2_e124_07", 7'h3F, 7'h07);
    check("rst2_e124_phase", 32'(phase), 32'd2);
    ped_req = 1'b1;
    do_reset();
    ped_req = 1'b0;
    check("rst2_phase", 32'(phase), 32'd0);
    check_disp("rst2_20", 7'h5B, 7'h3F);
    step(80); check("rst2_e80_phase", 32'(phase), 32'd1);
    check("rst2_e80_noack", 32'(ped_ack), 32'd0);

    step(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
